// File: rtl/xpmwrap_dpdistram_reader.sv
// Port B burst reader for the dual-port distributed RAM wrapper: sequential wrap-around reads,
// credit-limited skid FIFO, valid/ready output. Optional stall counter: XPMWRAP_DPDISTRAM_READER_PERF_EN.
module xpmwrap_dpdistram_reader #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_enb,
  output logic                  ram_regceb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [15:0]           stall_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q, rem_q;
  logic [READ_LATENCY:1] vld_pipe, last_pipe;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         fifo_count, inflight, credit_used;
  logic                  accept, issue, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept      = cmd_valid && cmd_ready;
  assign m_valid     = (fifo_count != '0);
  assign pop         = m_valid && m_ready;
  assign push        = vld_pipe[READ_LATENCY];
  assign m_data      = fifo_data[rd_ptr];
  assign m_last      = fifo_last[rd_ptr];
  assign ram_regceb  = 1'b1;
  assign ram_addrb   = addr_q;
  assign ram_enb     = issue;

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= READ_LATENCY; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  // Every issued read owns a FIFO slot from issue until pop, so the FIFO cannot overflow.
  assign credit_used = fifo_count + inflight;
  assign issue = (state == ISSUE) &&
                 ((credit_used < CW'(FIFO_DEPTH)) || ((credit_used == CW'(FIFO_DEPTH)) && pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state     <= ISSUE;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          addr_q    <= cmd_addr;
          rem_q     <= cmd_len;
        end
        ISSUE: if (issue) begin
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
          if (rem_q == '0) state <= DRAIN;
        end
        DRAIN: if (pop && m_last) begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline mirrors the RAM latency; a tag leaving the last stage marks valid ram_doutb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[1]  <= issue;
      last_pipe[1] <= issue && (rem_q == '0);
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      fifo_last  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= ram_doutb;
        fifo_last[wr_ptr] <= last_pipe[READ_LATENCY];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));

`ifdef XPMWRAP_DPDISTRAM_READER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         stall_cnt <= '0;
    else if (accept)                                    stall_cnt <= '0;
    else if (m_valid && !m_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_xpmwrap_dpdistram_reader.sv
// Bench for xpmwrap_dpdistram_reader: behavioural RAM, expected-word queue per burst, cycle timing.
module tb_xpmwrap_dpdistram_reader;
  localparam int AW = 6, DW = 32, LAT = 2, FD = LAT + 2, DEPTH = 1 << AW;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0, cmd_len = '0, ram_addrb;
  logic          ram_enb, ram_regceb;
  logic [DW-1:0] ram_doutb, m_data;
  logic          m_valid, m_ready = 1'b0, m_last, busy;
  logic [15:0]   stall_cnt;

  int checks = 0, errors = 0;
  int first_enb, enb_cnt, first_vld, last_pop, pops;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_s1, rd_s2;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_enb) rd_s1 <= mem[ram_addrb];
    if (ram_regceb) rd_s2 <= rd_s1;
  end
  assign ram_doutb = rd_s2;

  xpmwrap_dpdistram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_addrb(ram_addrb), .ram_enb(ram_enb),
    .ram_regceb(ram_regceb), .ram_doutb(ram_doutb), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .stall_cnt(stall_cnt)
  );

  // Issues one command and consumes the burst; mode selects the m_ready pattern.
  // Cycle numbers count from the accept edge (cycle 1 follows it). Returns early after abort_after pops.
  task automatic do_burst(input int addr, input int len, input int mode, input int abort_after);
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];
    logic [DW-1:0] prev_d, ed;
    logic          prev_l, prev_stall, el;
    int            cyc, limit;
    for (int i = 0; i <= len; i++) begin
      exp_d.push_back(mem[(addr + i) % DEPTH]);
      exp_l.push_back(i == len);
    end
    first_enb = -1; first_vld = -1; last_pop = -1; enb_cnt = 0; pops = 0;
    prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    limit = 20 * (len + 1) + 40;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_before_cmd got %b want 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_addr = addr[AW-1:0]; cmd_len = len[AW-1:0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (cyc = 1; cyc <= limit; cyc++) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       m_ready = !(cyc >= 4 && cyc <= 6);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (ram_enb) begin enb_cnt++; if (first_enb < 0) first_enb = cyc; end
      if (m_valid && first_vld < 0) first_vld = cyc;
      if (prev_stall) begin
        checks++;
        if (m_data !== prev_d || m_last !== prev_l) begin
          errors++;
          $display("FAIL hold_stable cyc %0d got %h/%b want %h/%b", cyc, m_data, m_last, prev_d, prev_l);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        el = 1'b0;
        if (exp_d.size() == 0) begin
          errors++; $display("FAIL extra_word cyc %0d got %h want none", cyc, m_data);
        end else begin
          ed = exp_d.pop_front(); el = exp_l.pop_front();
          if (m_data !== ed || m_last !== el) begin
            errors++;
            $display("FAIL word%0d got %h last %b want %h last %b", pops, m_data, m_last, ed, el);
          end
        end
        pops++;
        if (el) last_pop = cyc;
      end
      checks++;
      if (enb_cnt - pops > FD) begin
        errors++; $display("FAIL credit cyc %0d outstanding %0d want <= %0d", cyc, enb_cnt - pops, FD);
      end
      prev_stall = m_valid && !m_ready; prev_d = m_data; prev_l = m_last;
      if (last_pop >= 0) break;
      if (abort_after > 0 && pops == abort_after) return;
      @(posedge clk); #1;
    end
    if (last_pop < 0) begin
      errors++; $display("FAIL timeout pops %0d want %0d", pops, len + 1);
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL ready_after_last got ready %b busy %b want 1 0", cmd_ready, busy);
    end
    checks++;
    if (enb_cnt !== len + 1 || exp_d.size() != 0) begin
      errors++; $display("FAIL burst_count enb %0d left %0d want %0d 0", enb_cnt, exp_d.size(), len + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, ram_enb, ram_regceb, m_valid, m_last} !== 6'b100100) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 100100", {cmd_ready, busy, ram_enb, ram_regceb, m_valid, m_last});
    end
    checks++;
    if (ram_addrb !== '0 || m_data !== '0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h want 0 0 0", ram_addrb, m_data, stall_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    mem[5] = 32'hA5A5_0005;
    do_burst(5, 0, 0, 0);
    checks++;
    if (first_enb != 1 || enb_cnt != 1) begin
      errors++; $display("FAIL single_enb got first %0d cnt %0d want 1 1", first_enb, enb_cnt);
    end
    checks++;
    if (first_vld != 4 || last_pop != 4) begin
      errors++; $display("FAIL single_timing got vld %0d pop %0d want 4 4", first_vld, last_pop);
    end
  endtask

  task automatic test_burst4();
    do_burst(0, 3, 0, 0);
    checks++;
    if (first_vld != 4 || last_pop != 7) begin
      errors++; $display("FAIL burst4_timing got vld %0d last %0d want 4 7", first_vld, last_pop);
    end
  endtask

  task automatic test_backpressure();
    do_burst(int'($urandom_range(0, DEPTH - 1)), 7, 1, 0);
    checks++;
    if (pops != 8) begin errors++; $display("FAIL bp_pops got %0d want 8", pops); end
  endtask

  task automatic test_wrap();
    do_burst(62, 3, 0, 0);
    checks++;
    if (last_pop != 7) begin errors++; $display("FAIL wrap_timing got %0d want 7", last_pop); end
  endtask

  task automatic test_reset_mid_burst();
    do_burst(0, 63, 0, 10);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, busy, ram_enb, m_valid, m_last} !== 5'b10000) begin
      errors++; $display("FAIL midreset_ctrl got %b want 10000", {cmd_ready, busy, ram_enb, m_valid, m_last});
    end
    checks++;
    if (ram_addrb !== '0 || m_data !== '0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL midreset_data got %h %h %h want 0 0 0", ram_addrb, m_data, stall_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_burst(0, 3, 0, 0);
    checks++;
    if (first_vld != 4) begin errors++; $display("FAIL post_reset_vld got %0d want 4", first_vld); end
  endtask

  task automatic test_stall_cnt();
    logic [15:0] exp_stall;
`ifdef XPMWRAP_DPDISTRAM_READER_PERF_EN
    exp_stall = 16'd3;
`else
    exp_stall = 16'd0;
`endif
    do_burst(10, 3, 2, 0);
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt, exp_stall);
    end
    checks++;
    if (last_pop != 10) begin errors++; $display("FAIL stall_timing got %0d want 10", last_pop); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      do_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)), 3, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    test_reset();
    test_single_word();
    test_burst4();
    test_backpressure();
    test_wrap();
    test_reset_mid_burst();
    test_stall_cnt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
